// File: rtl/wvb_rr_arb_pkg.sv
// Shared constants and state encoding for the waveform-buffer round-robin arbiter.
package wvb_rr_arb_pkg;

    localparam int unsigned WVB_N_CHANNELS = 24;
    localparam int unsigned WVB_DATA_WIDTH = 170;
    localparam int unsigned WVB_HDR_WIDTH  = 113;
    localparam int unsigned WVB_IDX_WIDTH  = 5;
    localparam int unsigned WVB_TIMEOUT    = 4096;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wvb_rr_arb_rr_pick.sv
// Rotating-start priority encoder: first set request strictly after last_idx, wrapping.
module rr_pick
    import wvb_rr_arb_pkg::*;
#(
    parameter int unsigned N_CHANNELS  = WVB_N_CHANNELS,
    parameter int unsigned P_IDX_WIDTH = WVB_IDX_WIDTH
) (
    input  logic [N_CHANNELS-1:0]  req,
    input  logic [P_IDX_WIDTH-1:0] last_idx,
    output logic [P_IDX_WIDTH-1:0] next_idx,
    output logic                   any_req
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int pos;
        next_idx = last_idx;
        any_req  = |req;
        pos      = 0;
        for (int k = int'(N_CHANNELS); k > 0; k--) begin
            pos = (int'(last_idx) + k) % int'(N_CHANNELS);
            if (req[P_IDX_WIDTH'(pos)]) begin
                next_idx = P_IDX_WIDTH'(pos);
            end
        end
    end

endmodule

// File: rtl/wvb_rr_arb.sv
// Round-robin arbiter sharing one waveform-buffer consumer across N channels.
module wvb_rr_arb
    import wvb_rr_arb_pkg::*;
#(
    parameter int unsigned N_CHANNELS   = WVB_N_CHANNELS,
    parameter int unsigned P_DATA_WIDTH = WVB_DATA_WIDTH,
    parameter int unsigned P_HDR_WIDTH  = WVB_HDR_WIDTH,
    parameter int unsigned P_IDX_WIDTH  = WVB_IDX_WIDTH,
    parameter int unsigned P_TIMEOUT    = WVB_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [N_CHANNELS-1:0]             wvb_hdr_empty,
    input  logic [N_CHANNELS*P_HDR_WIDTH-1:0] wvb_hdr_data,
    input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
    output logic [N_CHANNELS-1:0]             wvb_hdr_rdreq,
    output logic [N_CHANNELS-1:0]             wvb_rdreq,
    output logic [N_CHANNELS-1:0]             wvb_rddone,
    output logic                              hdr_empty,
    output logic [P_HDR_WIDTH-1:0]            hdr_data,
    output logic [P_DATA_WIDTH-1:0]           data,
    input  logic                              hdr_rdreq,
    input  logic                              rdreq,
    input  logic                              rddone,
    output logic [P_IDX_WIDTH-1:0]            grant_idx,
    output logic                              busy,
    output logic                              timeout_err,
    output logic [31:0]                       n_grants
);

    localparam int unsigned CNT_W = $clog2(P_TIMEOUT + 1);

    arb_state_e              state_q, state_d;
    logic [P_IDX_WIDTH-1:0]  grant_idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_err_d;
    logic [31:0]             n_grants_d;
    logic [P_IDX_WIDTH-1:0]  pick_idx;
    logic                    pick_any;
    logic                    in_grant;

    // grant_idx doubles as last_idx: it holds the last granted channel outside GRANT.
    rr_pick #(
        .N_CHANNELS (N_CHANNELS),
        .P_IDX_WIDTH(P_IDX_WIDTH)
    ) u_pick (
        .req     (~wvb_hdr_empty),
        .last_idx(grant_idx),
        .next_idx(pick_idx),
        .any_req (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx   <= P_IDX_WIDTH'(N_CHANNELS - 1);
            cnt_q       <= '0;
            timeout_err <= 1'b0;
            n_grants    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx   <= grant_idx_d;
            cnt_q       <= cnt_d;
            timeout_err <= timeout_err_d;
            n_grants    <= n_grants_d;
        end
    end

    // Next-state logic; rddone takes precedence over a coincident timeout.
    always_comb begin
        state_d       = state_q;
        grant_idx_d   = grant_idx;
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err;
        n_grants_d    = n_grants;
        case (state_q)
            ST_IDLE: begin
                if (en && pick_any) begin
                    grant_idx_d = pick_idx;
                    cnt_d       = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rddone) begin
                    n_grants_d = n_grants + 32'd1;
                    state_d    = ST_RELEASE;
                end else if (cnt_q == CNT_W'(P_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign in_grant = (state_q == ST_GRANT);
    assign busy     = in_grant;

    // Zero-latency strobe routing and read-data muxing on the registered grant.
    always_comb begin
        wvb_hdr_rdreq = '0;
        wvb_rdreq     = '0;
        wvb_rddone    = '0;
        hdr_data      = '0;
        data          = '0;
        hdr_empty     = 1'b1;
        for (int i = 0; i < int'(N_CHANNELS); i++) begin
            if (grant_idx == P_IDX_WIDTH'(i)) begin
                hdr_data         = wvb_hdr_data[i*P_HDR_WIDTH +: P_HDR_WIDTH];
                data             = wvb_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                wvb_hdr_rdreq[i] = in_grant && hdr_rdreq;
                wvb_rdreq[i]     = in_grant && rdreq;
                wvb_rddone[i]    = in_grant && rddone;
                if (in_grant) begin
                    hdr_empty = wvb_hdr_empty[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_wvb_rr_arb.sv
// Directed self-checking bench for wvb_rr_arb.
`timescale 1ns/1ps
module tb_wvb_rr_arb;

    localparam int N  = 24;
    localparam int DW = 170;
    localparam int HW = 113;
    localparam int IW = 5;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [N-1:0]      wvb_hdr_empty;
    logic [N*HW-1:0]   wvb_hdr_data;
    logic [N*DW-1:0]   wvb_data;
    logic [N-1:0]      wvb_hdr_rdreq;
    logic [N-1:0]      wvb_rdreq;
    logic [N-1:0]      wvb_rddone;
    logic              hdr_empty;
    logic [HW-1:0]     hdr_data;
    logic [DW-1:0]     data;
    logic              hdr_rdreq;
    logic              rdreq;
    logic              rddone;
    logic [IW-1:0]     grant_idx;
    logic              busy;
    logic              timeout_err;
    logic [31:0]       n_grants;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_ng  = 0;

    always #5 clk = ~clk;

    wvb_rr_arb #(
        .N_CHANNELS  (N),
        .P_DATA_WIDTH(DW),
        .P_HDR_WIDTH (HW),
        .P_IDX_WIDTH (IW),
        .P_TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .wvb_hdr_empty(wvb_hdr_empty),
        .wvb_hdr_data (wvb_hdr_data),
        .wvb_data     (wvb_data),
        .wvb_hdr_rdreq(wvb_hdr_rdreq),
        .wvb_rdreq    (wvb_rdreq),
        .wvb_rddone   (wvb_rddone),
        .hdr_empty    (hdr_empty),
        .hdr_data     (hdr_data),
        .data         (data),
        .hdr_rdreq    (hdr_rdreq),
        .rdreq        (rdreq),
        .rddone       (rddone),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .n_grants     (n_grants)
    );

    function automatic logic [HW-1:0] gen_hdr(input int ch);
        logic [HW-1:0] v;
        for (int b = 0; b < HW; b++) v[b] = (((b * 3) + (ch * 11)) % 7) < 3;
        return v;
    endfunction

    function automatic logic [DW-1:0] gen_data(input int ch);
        logic [DW-1:0] v;
        for (int b = 0; b < DW; b++) v[b] = (((b * 5) + (ch * 13)) % 11) < 5;
        return v;
    endfunction

    function automatic logic [N-1:0] onehot(input int ch);
        logic [N-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; wvb_hdr_empty = '1;
        hdr_rdreq = 1'b1; rdreq = 1'b1; rddone = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", busy); end
        vec_cnt++; if (hdr_empty !== 1'b1) begin err_cnt++; $display("FAIL rst_hdr_empty: got %b want 1", hdr_empty); end
        vec_cnt++; if (grant_idx !== IW'(N - 1)) begin err_cnt++; $display("FAIL rst_grant_idx: got %0d want %0d", grant_idx, N - 1); end
        vec_cnt++; if (n_grants !== 32'd0) begin err_cnt++; $display("FAIL rst_n_grants: got %0d want 0", n_grants); end
        vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        vec_cnt++; if ((wvb_rdreq | wvb_hdr_rdreq | wvb_rddone) !== '0) begin err_cnt++; $display("FAIL rst_strobes: got %h want 0", wvb_rdreq | wvb_hdr_rdreq | wvb_rddone); end
        hdr_rdreq = 1'b0; rdreq = 1'b0; rddone = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_first_pair();
        en = 1'b1;
        wvb_hdr_empty = '1; wvb_hdr_empty[5] = 1'b0; wvb_hdr_empty[23] = 1'b0;
        step();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL pair_busy_latency: got %b want 1", busy); end
        vec_cnt++; if (grant_idx !== IW'(5)) begin err_cnt++; $display("FAIL pair_first_idx: got %0d want 5", grant_idx); end
        vec_cnt++; if (hdr_empty !== 1'b0) begin err_cnt++; $display("FAIL pair_hdr_empty: got %b want 0", hdr_empty); end
        rddone = 1'b1;
        #1;
        vec_cnt++; if (wvb_rddone !== onehot(5)) begin err_cnt++; $display("FAIL pair_rddone5: got %h want %h", wvb_rddone, onehot(5)); end
        wvb_hdr_empty[5] = 1'b1;
        step();
        rddone = 1'b0; exp_ng++;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL pair_release_busy: got %b want 0", busy); end
        step();
        step();
        vec_cnt++; if (grant_idx !== IW'(23) || busy !== 1'b1) begin err_cnt++; $display("FAIL pair_second_idx: got %0d busy %b want 23 busy 1", grant_idx, busy); end
        rddone = 1'b1; wvb_hdr_empty[23] = 1'b1;
        step();
        rddone = 1'b0; exp_ng++;
        step();
        step();
        vec_cnt++; if (n_grants !== 32'(exp_ng)) begin err_cnt++; $display("FAIL pair_n_grants: got %0d want %0d", n_grants, exp_ng); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL pair_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        wvb_hdr_empty = '0;
        for (int g = 0; g < 2 * N; g++) begin
            int waits;
            waits = 0;
            while (busy !== 1'b1 && waits < 6) begin
                step();
                waits++;
            end
            vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rr_grant_timeout: grant %0d never issued", g); end
            vec_cnt++; if (grant_idx !== IW'(g % N)) begin err_cnt++; $display("FAIL rr_sequence: grant %0d got %0d want %0d", g, grant_idx, g % N); end
            if (g > 0) begin
                vec_cnt++; if (waits != 2) begin err_cnt++; $display("FAIL rr_turnaround: grant %0d got %0d want 2", g, waits); end
            end
            rddone = 1'b1;
            step();
            rddone = 1'b0; exp_ng++;
        end
        wvb_hdr_empty = '1;
        step();
        step();
        vec_cnt++; if (n_grants !== 32'(exp_ng)) begin err_cnt++; $display("FAIL rr_n_grants: got %0d want %0d", n_grants, exp_ng); end
    endtask

    task automatic test_routing();
        int waits;
        wvb_hdr_empty = '1; wvb_hdr_empty[7] = 1'b0;
        waits = 0;
        while (busy !== 1'b1 && waits < 4) begin
            step();
            waits++;
        end
        vec_cnt++; if (busy !== 1'b1 || grant_idx !== IW'(7)) begin err_cnt++; $display("FAIL route_grant7: got %0d busy %b want 7 busy 1", grant_idx, busy); end
        hdr_rdreq = 1'b1; rdreq = 1'b1;
        #1;
        vec_cnt++; if (wvb_hdr_rdreq !== onehot(7)) begin err_cnt++; $display("FAIL route_hdr_rdreq: got %h want %h", wvb_hdr_rdreq, onehot(7)); end
        vec_cnt++; if (wvb_rdreq !== onehot(7)) begin err_cnt++; $display("FAIL route_rdreq: got %h want %h", wvb_rdreq, onehot(7)); end
        vec_cnt++; if (wvb_rddone !== '0) begin err_cnt++; $display("FAIL route_rddone_idle: got %h want 0", wvb_rddone); end
        vec_cnt++; if (data !== gen_data(7)) begin err_cnt++; $display("FAIL route_data: got %h want %h", data, gen_data(7)); end
        vec_cnt++; if (hdr_data !== gen_hdr(7)) begin err_cnt++; $display("FAIL route_hdr_data: got %h want %h", hdr_data, gen_hdr(7)); end
        step();
        hdr_rdreq = 1'b0; rdreq = 1'b0;
        #1;
        vec_cnt++; if ((wvb_rdreq | wvb_hdr_rdreq) !== '0) begin err_cnt++; $display("FAIL route_strobe_drop: got %h want 0", wvb_rdreq | wvb_hdr_rdreq); end
        rddone = 1'b1; wvb_hdr_empty[7] = 1'b1;
        step();
        rddone = 1'b0; exp_ng++;
        rdreq = 1'b1;
        #1;
        vec_cnt++; if (wvb_rdreq !== '0 || hdr_empty !== 1'b1) begin err_cnt++; $display("FAIL route_release_gate: got %h empty %b want 0 empty 1", wvb_rdreq, hdr_empty); end
        rdreq = 1'b0;
        step();
    endtask

    task automatic test_enable();
        en = 1'b0; wvb_hdr_empty[3] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            vec_cnt++; if (busy !== 1'b0 || hdr_empty !== 1'b1) begin err_cnt++; $display("FAIL en_hold: cycle %0d busy %b empty %b want 0 1", c, busy, hdr_empty); end
        end
        en = 1'b1;
        step();
        vec_cnt++; if (busy !== 1'b1 || grant_idx !== IW'(3)) begin err_cnt++; $display("FAIL en_grant3: got %0d busy %b want 3 busy 1", grant_idx, busy); end
        en = 1'b0; rddone = 1'b1;
        #1;
        vec_cnt++; if (wvb_rddone !== onehot(3)) begin err_cnt++; $display("FAIL en_drop_completes: got %h want %h", wvb_rddone, onehot(3)); end
        wvb_hdr_empty[3] = 1'b1;
        step();
        rddone = 1'b0; exp_ng++;
        step();
        vec_cnt++; if (n_grants !== 32'(exp_ng)) begin err_cnt++; $display("FAIL en_n_grants: got %0d want %0d", n_grants, exp_ng); end
        en = 1'b1;
    endtask

    task automatic test_timeout_race();
        int waits;
        wvb_hdr_empty[10] = 1'b0;
        waits = 0;
        while (busy !== 1'b1 && waits < 4) begin
            step();
            waits++;
        end
        vec_cnt++; if (busy !== 1'b1 || grant_idx !== IW'(10)) begin err_cnt++; $display("FAIL race_grant10: got %0d busy %b want 10 busy 1", grant_idx, busy); end
        repeat (TO - 1) step();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL race_early_release: got busy %b want 1", busy); end
        rddone = 1'b1;
        #1;
        vec_cnt++; if (wvb_rddone !== onehot(10)) begin err_cnt++; $display("FAIL race_rddone: got %h want %h", wvb_rddone, onehot(10)); end
        wvb_hdr_empty[10] = 1'b1;
        step();
        rddone = 1'b0; exp_ng++;
        vec_cnt++; if (timeout_err !== 1'b0) begin err_cnt++; $display("FAIL race_timeout_err: got %b want 0", timeout_err); end
        vec_cnt++; if (n_grants !== 32'(exp_ng) || busy !== 1'b0) begin err_cnt++; $display("FAIL race_completion: got %0d busy %b want %0d busy 0", n_grants, busy, exp_ng); end
    endtask

    task automatic test_timeout();
        int waits;
        int n;
        wvb_hdr_empty[2] = 1'b0; wvb_hdr_empty[3] = 1'b0;
        waits = 0;
        while (busy !== 1'b1 && waits < 5) begin
            step();
            waits++;
        end
        vec_cnt++; if (busy !== 1'b1 || grant_idx !== IW'(2)) begin err_cnt++; $display("FAIL to_grant2: got %0d busy %b want 2 busy 1", grant_idx, busy); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            vec_cnt++; if (wvb_rddone !== '0) begin err_cnt++; $display("FAIL to_no_rddone: cycle %0d got %h want 0", n, wvb_rddone); end
            step();
        end
        vec_cnt++; if (n != TO) begin err_cnt++; $display("FAIL to_grant_cycles: got %0d want %0d", n, TO); end
        vec_cnt++; if (timeout_err !== 1'b1) begin err_cnt++; $display("FAIL to_flag: got %b want 1", timeout_err); end
        vec_cnt++; if (n_grants !== 32'(exp_ng)) begin err_cnt++; $display("FAIL to_n_grants: got %0d want %0d", n_grants, exp_ng); end
        waits = 0;
        while (busy !== 1'b1 && waits < 5) begin
            step();
            waits++;
        end
        vec_cnt++; if (busy !== 1'b1 || grant_idx !== IW'(3)) begin err_cnt++; $display("FAIL to_next_grant3: got %0d busy %b want 3 busy 1", grant_idx, busy); end
    endtask

    task automatic test_async_reset();
        hdr_rdreq = 1'b1; rdreq = 1'b1;
        #1;
        vec_cnt++; if (wvb_rdreq !== onehot(3)) begin err_cnt++; $display("FAIL arst_pre_rdreq: got %h want %h", wvb_rdreq, onehot(3)); end
        #1;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL arst_busy: got %b want 0", busy); end
        vec_cnt++; if ((wvb_rdreq | wvb_hdr_rdreq | wvb_rddone) !== '0) begin err_cnt++; $display("FAIL arst_strobes: got %h want 0", wvb_rdreq | wvb_hdr_rdreq | wvb_rddone); end
        vec_cnt++; if (n_grants !== 32'd0) begin err_cnt++; $display("FAIL arst_n_grants: got %0d want 0", n_grants); end
        vec_cnt++; if (hdr_empty !== 1'b1) begin err_cnt++; $display("FAIL arst_hdr_empty: got %b want 1", hdr_empty); end
        vec_cnt++; if (timeout_err !== 1'b0 || grant_idx !== IW'(N - 1)) begin err_cnt++; $display("FAIL arst_regs: got terr %b idx %0d want 0 %0d", timeout_err, grant_idx, N - 1); end
        hdr_rdreq = 1'b0; rdreq = 1'b0;
        step();
    endtask

    initial begin
        for (int ch = 0; ch < N; ch++) begin
            wvb_hdr_data[ch*HW +: HW] = gen_hdr(ch);
            wvb_data[ch*DW +: DW]     = gen_data(ch);
        end
        test_reset();
        test_first_pair();
        test_round_robin();
        test_routing();
        test_enable();
        test_timeout_race();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
